hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller. Receives hazard status back from the ID/EX and EX stages and
//  drives stall, flush and freeze controls upstream to the PC, IF/ID and ID/EX registers.
//  Covers three cases: load-use stalls, redirect flushes for taken branch, jump, JR and JAL,
//  and whole-pipe freeze while data memory is busy. Keeps saturating stall and flush counters.
// PARAMETERS
//  LOAD_USE_STALLS  1   bubbles per load-use hazard, >=1
//  FLUSH_CYCLES     1   cycles IF/ID+ID/EX flushed per redirect, >=1
//  CNT_W            16  width of performance counters
// PORTS
//  clk             in   1      clock, all state on rising edge
//  reset           in   1      synchronous, active-high
//  idRsIn          in   5      rs field of instruction in ID
//  idRtIn          in   5      rt field of instruction in ID
//  idUsesRtIn      in   1      ID instruction reads rt as a source (R-type, beq/bne, sw)
//  exMemReadIn     in   1      memReadOut of ID/EX (load in EX)
//  exRtIn          in   5      rt field of instruction in EX (load destination)
//  exBranchTakenIn in   1      EX resolved beq/bne taken
//  exJumpIn        in   1      jumpOut|JROut|JALOut of ID/EX
//  memBusyIn       in   1      data memory not ready
//  pcWrite         out  1      PC load enable
//  ifidWrite       out  1      IF/ID load enable
//  ifidFlush       out  1      IF/ID loads zero on next edge
//  idexFlush       out  1      ID/EX loads zero (bubble) on next edge
//  pipeFreeze      out  1      all pipeline registers hold
//  stateOut        out  2      current FSM state
//  stallCount      out  CNT_W  load-use bubble cycles, saturating
//  flushCount      out  CNT_W  redirect events, saturating
// BEHAVIOUR
//  - Reset, checked on the clk edge: state=RUN, cnt=0, retState=RUN, counters=0.
//    While reset is high, all control outputs are 0.
//  - redirect = exBranchTakenIn | exJumpIn.
//  - loadUse = exMemReadIn & exRtIn!=0 & (exRtIn==idRsIn | (idUsesRtIn & exRtIn==idRtIn)).
//  - Controls are combinational from state and inputs. The same edge commits them.
//  - Priority each cycle: memBusy > redirect > loadUse > none.
//  - Default outputs: pcWrite=1, ifidWrite=1, ifidFlush=0, idexFlush=0, pipeFreeze=0.
//  - memBusyIn=1, in any state:
//    - pipeFreeze=1, pcWrite=0, ifidWrite=0, no flush.
//    - If not already FREEZE: retState<=state, then go FREEZE. cnt is held.
//  - FREEZE:
//    - memBusyIn=0: return to retState with cnt unchanged.
//    - That same cycle is evaluated as the restored state.
//  - RUN:
//    - redirect: ifidFlush=1, idexFlush=1, pcWrite=1. flushCount+1.
//      If FLUSH_CYCLES>1: go FLUSH, cnt<=FLUSH_CYCLES-1.
//    - loadUse: pcWrite=0, ifidWrite=0, idexFlush=1. stallCount+1.
//      If LOAD_USE_STALLS>1: go LOAD_STALL, cnt<=LOAD_USE_STALLS-1.
//  - LOAD_STALL:
//    - Outputs as loadUse. stallCount+1 per cycle. cnt-1.
//    - Return to RUN on the edge where cnt==1.
//    - A redirect here is handled as in RUN (restarts). The stall is abandoned.
//  - FLUSH:
//    - ifidFlush=1, idexFlush=1, pcWrite=1. cnt-1. RUN when cnt==1.
//    - A new redirect reloads cnt and adds flushCount+1.
//  - Counters saturate at all-ones. FREEZE cycles are never counted.
//  - Reset mid-stall or mid-freeze: state is discarded and the next cycle is RUN.
// STRUCTURE
//  - mips_pkg holds:
//    - HZ_RUN=2'd0, HZ_LOAD_STALL=2'd1, HZ_FLUSH=2'd2, HZ_FREEZE=2'd3.
//    - REG_W=5, REG_ZERO=5'd0.
//  - Sub-module sat_counter (parameter W; ports clk, reset, inc, count).
//    Instantiated for stallCount and flushCount.
//  - FSM, cnt and retState live in hazard_ctrl.
// TESTING
//  1. Load in EX with exRtIn=8, idRsIn=8, defaults (stalls 1):
//     one cycle pcWrite=0, ifidWrite=0, idexFlush=1, stallCount=1.
//  2. exRtIn=0 with exMemReadIn=1 and idRsIn=0: no stall, pcWrite=1.
//     Repeat with idUsesRtIn=0 and rt match: no stall.
//  3. exBranchTakenIn=1 in RUN, FLUSH_CYCLES=2:
//     2 cycles ifidFlush=idexFlush=1, flushCount=1, then RUN.
//  4. LOAD_USE_STALLS=3, memBusyIn high 4 cycles after the 1st stall cycle:
//     pipeFreeze=1 for 4 cycles, then 2 more stall cycles. stallCount=3.
//  5. Redirect and loadUse asserted together: flush only. stallCount=0, flushCount=1.
//  6. Force 2^CNT_W+5 stall cycles: stallCount holds at all-ones.
//     Pulse reset mid-LOAD_STALL: stateOut=0, counters=0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared register-field constants and hazard controller state encoding.
package mips_pkg;
   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
   typedef enum logic [1:0] {
      HZ_RUN        = 2'd0,
      HZ_LOAD_STALL = 2'd1,
      HZ_FLUSH      = 2'd2,
      HZ_FREEZE     = 2'd3
   } hz_state_e;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);
   always_ff @(posedge clk) begin
      if (reset) count <= '0;
      else if (inc && !(&count)) count <= count + W'(1);
   end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, redirect flush and memory-busy freeze control
// for the pipeline front end, with saturating stall/flush counters.
module hazard_ctrl
   import mips_pkg::*;
#(
   parameter int LOAD_USE_STALLS = 1,
   parameter int FLUSH_CYCLES    = 1,
   parameter int CNT_W           = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] idRsIn,
   input  logic [REG_W-1:0] idRtIn,
   input  logic             idUsesRtIn,
   input  logic             exMemReadIn,
   input  logic [REG_W-1:0] exRtIn,
   input  logic             exBranchTakenIn,
   input  logic             exJumpIn,
   input  logic             memBusyIn,
   output logic             pcWrite,
   output logic             ifidWrite,
   output logic             ifidFlush,
   output logic             idexFlush,
   output logic             pipeFreeze,
   output logic [1:0]       stateOut,
   output logic [CNT_W-1:0] stallCount,
   output logic [CNT_W-1:0] flushCount
);
   localparam int MAXC = (LOAD_USE_STALLS > FLUSH_CYCLES) ? LOAD_USE_STALLS : FLUSH_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   hz_state_e     state, ret_state, eff;
   logic [CW-1:0] cnt;
   logic          redirect, load_use, do_flush, do_stall, live;
   // Leaving FREEZE, the cycle behaves as the state that was interrupted.
   always_comb begin
      eff      = (state == HZ_FREEZE) ? ret_state : state;
      live     = ~reset & ~memBusyIn;
      redirect = exBranchTakenIn | exJumpIn;
      load_use = exMemReadIn && exRtIn != REG_ZERO &&
                 (exRtIn == idRsIn || (idUsesRtIn && exRtIn == idRtIn));
      do_flush = live & (redirect | (eff == HZ_FLUSH));
      do_stall = live & ~do_flush & ((eff == HZ_LOAD_STALL) | ((eff == HZ_RUN) & load_use));
   end
   assign pcWrite    = live & ~do_stall;
   assign ifidWrite  = live & ~do_stall;
   assign ifidFlush  = do_flush;
   assign idexFlush  = do_flush | do_stall;
   assign pipeFreeze = ~reset & memBusyIn;
   assign stateOut   = state;
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= HZ_RUN;
         ret_state <= HZ_RUN;
         cnt       <= '0;
      end else if (memBusyIn) begin
         if (state != HZ_FREEZE) begin
            ret_state <= state;
            state     <= HZ_FREEZE;
         end
      end else if (redirect) begin
         state <= (FLUSH_CYCLES > 1) ? HZ_FLUSH : HZ_RUN;
         cnt   <= CW'(FLUSH_CYCLES - 1);
      end else if (eff == HZ_FLUSH || eff == HZ_LOAD_STALL) begin
         state <= (cnt == CW'(1)) ? HZ_RUN : eff;
         cnt   <= cnt - CW'(1);
      end else if (load_use) begin
         state <= (LOAD_USE_STALLS > 1) ? HZ_LOAD_STALL : HZ_RUN;
         cnt   <= CW'(LOAD_USE_STALLS - 1);
      end else begin
         state <= HZ_RUN;
      end
   end
   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk(clk), .reset(reset), .inc(do_stall), .count(stallCount)
   );
   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk(clk), .reset(reset), .inc(do_flush & redirect), .count(flushCount)
   );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: two controller configurations driven in lockstep and checked
// every cycle against a remaining-cycles reference model.
module tb_hazard_ctrl;
   logic clk = 1'b0;
   logic reset;
   logic [4:0] idRsIn, idRtIn, exRtIn;
   logic idUsesRtIn, exMemReadIn, exBranchTakenIn, exJumpIn, memBusyIn;
   logic [1:0][6:0] ctl;
   logic [1:0][7:0] sc, fc;
   int checks = 0, errors = 0;
   int lus [2] = '{1, 3};
   int fcy [2] = '{1, 2};
   int srem [2], frem [2], scnt [2], fcnt [2];
   bit frz [2];
   always #5 clk = ~clk;
   hazard_ctrl #(.LOAD_USE_STALLS(1), .FLUSH_CYCLES(1), .CNT_W(8)) u_a (
      .clk(clk), .reset(reset), .idRsIn(idRsIn), .idRtIn(idRtIn), .idUsesRtIn(idUsesRtIn),
      .exMemReadIn(exMemReadIn), .exRtIn(exRtIn), .exBranchTakenIn(exBranchTakenIn),
      .exJumpIn(exJumpIn), .memBusyIn(memBusyIn), .pcWrite(ctl[0][6]), .ifidWrite(ctl[0][5]),
      .ifidFlush(ctl[0][4]), .idexFlush(ctl[0][3]), .pipeFreeze(ctl[0][2]),
      .stateOut(ctl[0][1:0]), .stallCount(sc[0]), .flushCount(fc[0])
   );
   hazard_ctrl #(.LOAD_USE_STALLS(3), .FLUSH_CYCLES(2), .CNT_W(8)) u_b (
      .clk(clk), .reset(reset), .idRsIn(idRsIn), .idRtIn(idRtIn), .idUsesRtIn(idUsesRtIn),
      .exMemReadIn(exMemReadIn), .exRtIn(exRtIn), .exBranchTakenIn(exBranchTakenIn),
      .exJumpIn(exJumpIn), .memBusyIn(memBusyIn), .pcWrite(ctl[1][6]), .ifidWrite(ctl[1][5]),
      .ifidFlush(ctl[1][4]), .idexFlush(ctl[1][3]), .pipeFreeze(ctl[1][2]),
      .stateOut(ctl[1][1:0]), .stallCount(sc[1]), .flushCount(fc[1])
   );
   task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // Model: outstanding bubble/flush cycles as plain integers; freeze just pauses them.
   task automatic cycle();
      logic [6:0] e;
      logic [1:0] code;
      bit ld, rd;
      @(negedge clk);
      ld = exMemReadIn && exRtIn != 0 && (exRtIn == idRsIn || (idUsesRtIn && exRtIn == idRtIn));
      rd = exBranchTakenIn || exJumpIn;
      for (int d = 0; d < 2; d++) begin
         code = frz[d] ? 2'd3 : (frem[d] > 0) ? 2'd2 : (srem[d] > 0) ? 2'd1 : 2'd0;
         check8($sformatf("stall_count%0d", d), sc[d], 8'(scnt[d]));
         check8($sformatf("flush_count%0d", d), fc[d], 8'(fcnt[d]));
         if (reset) begin
            e = {5'b00000, code};
            srem[d] = 0; frem[d] = 0; scnt[d] = 0; fcnt[d] = 0; frz[d] = 0;
         end else if (memBusyIn) begin
            e = {5'b00001, code};
            frz[d] = 1;
         end else begin
            frz[d] = 0;
            if (rd) begin
               e = {5'b11110, code};
               fcnt[d] = (fcnt[d] < 255) ? fcnt[d] + 1 : 255;
               frem[d] = fcy[d] - 1;
               srem[d] = 0;
            end else if (frem[d] > 0) begin
               e = {5'b11110, code};
               frem[d]--;
            end else if (srem[d] > 0 || ld) begin
               e = {5'b00010, code};
               scnt[d] = (scnt[d] < 255) ? scnt[d] + 1 : 255;
               srem[d] = (srem[d] > 0) ? srem[d] - 1 : lus[d] - 1;
            end else begin
               e = {5'b11000, code};
            end
         end
         check8($sformatf("ctl%0d", d), {1'b0, ctl[d]}, {1'b0, e});
      end
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input bit r, bsy, br, jp, mr, uses, input logic [4:0] rs, rt, ert);
      reset = r; memBusyIn = bsy; exBranchTakenIn = br; exJumpIn = jp; exMemReadIn = mr;
      idUsesRtIn = uses; idRsIn = rs; idRtIn = rt; exRtIn = ert;
      cycle();
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
   endtask
   initial begin
      drive(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      drive(1, 1, 1, 0, 1, 1, 5'd8, 5'd8, 5'd8);
      idle(1);
      drive(0, 0, 0, 0, 1, 0, 5'd8, 5'd0, 5'd8);
      idle(4);
      drive(0, 0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0);
      drive(0, 0, 0, 0, 1, 0, 5'd1, 5'd9, 5'd9);
      idle(2);
      drive(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      idle(3);
      drive(0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
      idle(3);
      drive(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      drive(0, 0, 0, 0, 1, 1, 5'd3, 5'd8, 5'd8);
      for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 1, 1, 5'd3, 5'd8, 5'd8);
      idle(4);
      check8("freeze_stall_b", sc[1], 8'd3);
      drive(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      drive(0, 0, 1, 0, 1, 0, 5'd8, 5'd0, 5'd8);
      idle(3);
      check8("both_stall_a", sc[0], 8'd0);
      check8("both_flush_a", fc[0], 8'd1);
      for (int i = 0; i < 261; i++) drive(0, 0, 0, 0, 1, 0, 5'd4, 5'd0, 5'd4);
      check8("sat_stall_a", sc[0], 8'hff);
      idle(3);
      drive(0, 0, 0, 0, 1, 0, 5'd4, 5'd0, 5'd4);
      drive(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      check8("rst_state_b", {6'd0, ctl[1][1:0]}, 8'd0);
      check8("rst_stall_b", sc[1], 8'd0);
      for (int i = 0; i < 2000; i++)
         drive($urandom_range(99) == 0, $urandom_range(5) == 0, $urandom_range(7) == 0,
               $urandom_range(11) == 0, $urandom_range(2) == 0, 1'($urandom),
               5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
